// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg
// Shared types and encodings for the LC-3 subset instruction sequencer:
// the FSM state enum, opcode constants, and the PCSelect, ADDR2Select and
// ALU mode encodings seen by the datapath.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_S18, ST_S33, ST_S35, ST_S32,
    ST_S1,  ST_S5,  ST_S9,
    ST_S0,  ST_S22,
    ST_S12,
    ST_S4,  ST_S21,
    ST_S6,  ST_S25, ST_S27,
    ST_S7,  ST_S23, ST_S16,
    ST_P1,  ST_P2
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCSEL_INC   = 2'b00;
  localparam logic [1:0] PCSEL_BUS   = 2'b01;
  localparam logic [1:0] PCSEL_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_AND  = 2'b01;
  localparam logic [1:0] MODE_NOT  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  // States that hold the SRAM strobe for MEM_WAIT cycles.
  function automatic logic is_mem_state(state_t s);
    return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
  endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// ctrl_wait_counter
// 4-bit down-counter that times the memory access states.
// Ports:
//   clk, rst  - clock, async active-high reset (count -> 0)
//   load      - load load_val (takes priority over dec)
//   load_val  - reload value, MEM_WAIT-1
//   dec       - decrement, saturating at 0
//   done      - terminal count reached (count == 0)
module ctrl_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm
// Instruction sequencer for the LC-3 subset datapath. Drives every load
// enable, bus gate and mux select plus the active-low SRAM strobes.
// Ports:
//   Clk, Reset      - clock, async active-high reset (-> HALTED)
//   Run, Continue   - start from HALTED, resume from PAUSE (levels)
//   IR, BEN         - datapath instruction register and branch enable
//   LD_*            - register load enables
//   SBus*           - bus gates, at most one high per cycle
//   *Select, mode   - datapath mux selects and ALU op
//   MIO_EN          - MDR source (1 = memory)
//   Mem_OE, Mem_WE  - active-low SRAM strobes
//
// state  | meaning
// HALTED | idle, waiting for Run
// S18    | MAR <- PC, PC <- PC+1
// S33    | memory read (instruction), MDR loaded on last wait cycle
// S35    | IR <- MDR
// S32    | decode, BEN <- branch condition
// S1/5/9 | ADD / AND / NOT into DR, set CC
// S0/S22 | BR test / PC <- PC+off9
// S12    | JMP: PC <- SR1
// S4/S21 | JSR: R7 <- PC, PC <- PC+off11
// S6/S25 | LDR: MAR <- SR1+off6, memory read
// S27    | LDR: DR <- MDR, set CC
// S7/S23 | STR: MAR <- SR1+off6, MDR <- SR
// S16    | STR: memory write
// P1/P2  | PAUSE: wait Continue high, then low
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_BEN,
  output logic        SBusPC,
  output logic        SBusMDR,
  output logic        SBusALU,
  output logic        SBusMARMUX,
  output logic [1:0]  PCSelect,
  output logic [1:0]  ADDR2Select,
  output logic        ADDR1Select,
  output logic        DRSelect,
  output logic        SR1Select,
  output logic        SR2Select,
  output logic [1:0]  mode,
  output logic        MIO_EN,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t state, next_state;
  logic   wait_done;
  logic   wait_load;

  // Register fields decoded by the datapath, not by the sequencer.
  logic   unused_ir;
  assign unused_ir = ^{IR[11:6], IR[4:0]};

  // Reload only on entry so the count runs down across the whole stay.
  assign wait_load = is_mem_state(next_state) && (next_state != state);

  ctrl_wait_counter u_wait (
    .clk      (Clk),
    .rst      (Reset),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .dec      (is_mem_state(state)),
    .done     (wait_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_HALTED;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    LD_MAR      = 1'b0;
    LD_MDR      = 1'b0;
    LD_IR       = 1'b0;
    LD_PC       = 1'b0;
    LD_REG      = 1'b0;
    LD_CC       = 1'b0;
    LD_BEN      = 1'b0;
    SBusPC      = 1'b0;
    SBusMDR     = 1'b0;
    SBusALU     = 1'b0;
    SBusMARMUX  = 1'b0;
    PCSelect    = PCSEL_INC;
    ADDR2Select = ADDR2_ZERO;
    ADDR1Select = 1'b0;
    DRSelect    = 1'b0;
    SR1Select   = 1'b0;
    SR2Select   = 1'b0;
    mode        = MODE_ADD;
    MIO_EN      = 1'b0;
    Mem_OE      = 1'b1;
    Mem_WE      = 1'b1;

    unique case (state)
      ST_HALTED: if (Run) next_state = ST_S18;
      ST_S18: begin
        SBusPC     = 1'b1;
        LD_MAR     = 1'b1;
        PCSelect   = PCSEL_INC;
        LD_PC      = 1'b1;
        next_state = ST_S33;
      end
      ST_S33, ST_S25: begin
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        if (wait_done) begin
          LD_MDR     = 1'b1;
          next_state = (state == ST_S33) ? ST_S35 : ST_S27;
        end
      end
      ST_S35: begin
        SBusMDR    = 1'b1;
        LD_IR      = 1'b1;
        next_state = ST_S32;
      end
      ST_S32: begin
        LD_BEN = 1'b1;
        case (IR[15:12])
          OP_ADD:   next_state = ST_S1;
          OP_AND:   next_state = ST_S5;
          OP_NOT:   next_state = ST_S9;
          OP_BR:    next_state = ST_S0;
          OP_JMP:   next_state = ST_S12;
          OP_JSR:   next_state = ST_S4;
          OP_LDR:   next_state = ST_S6;
          OP_STR:   next_state = ST_S7;
          OP_PAUSE: next_state = ST_P1;
          default:  next_state = ST_S18;
        endcase
      end
      ST_S1, ST_S5, ST_S9: begin
        SR1Select  = 1'b1;
        SR2Select  = IR[5];
        mode       = (state == ST_S1) ? MODE_ADD :
                     (state == ST_S5) ? MODE_AND : MODE_NOT;
        SBusALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = ST_S18;
      end
      ST_S0: next_state = BEN ? ST_S22 : ST_S18;
      ST_S22: begin
        ADDR2Select = ADDR2_OFF9;
        PCSelect    = PCSEL_ADDER;
        LD_PC       = 1'b1;
        next_state  = ST_S18;
      end
      ST_S12: begin
        SR1Select   = 1'b1;
        ADDR1Select = 1'b1;
        ADDR2Select = ADDR2_ZERO;
        PCSelect    = PCSEL_ADDER;
        LD_PC       = 1'b1;
        next_state  = ST_S18;
      end
      ST_S4: begin
        SBusPC     = 1'b1;
        DRSelect   = 1'b1;
        LD_REG     = 1'b1;
        next_state = ST_S21;
      end
      ST_S21: begin
        ADDR2Select = ADDR2_OFF11;
        PCSelect    = PCSEL_ADDER;
        LD_PC       = 1'b1;
        next_state  = ST_S18;
      end
      ST_S6, ST_S7: begin
        SR1Select   = 1'b1;
        ADDR1Select = 1'b1;
        ADDR2Select = ADDR2_OFF6;
        SBusMARMUX  = 1'b1;
        LD_MAR      = 1'b1;
        next_state  = (state == ST_S6) ? ST_S25 : ST_S23;
      end
      ST_S27: begin
        SBusMDR    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = ST_S18;
      end
      ST_S23: begin
        mode       = MODE_PASS;
        SBusALU    = 1'b1;
        LD_MDR     = 1'b1;
        next_state = ST_S16;
      end
      ST_S16: begin
        Mem_WE = 1'b0;
        if (wait_done) next_state = ST_S18;
      end
      ST_P1: if (Continue)  next_state = ST_P2;
      ST_P2: if (!Continue) next_state = ST_S18;
      default: next_state = ST_HALTED;
    endcase
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
module tb_lc3_ctrl_fsm;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
    logic       g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcsel, a2sel;
    logic       a1sel, drsel, sr1sel, sr2sel;
    logic [1:0] mode;
    logic       mio, oe, we;
  } ovec_t;

  typedef enum {B_IDLE, B_S18, B_S33, B_S35, B_S32, B_S1, B_S5, B_S9, B_S0,
                B_S22, B_S12, B_S4, B_S21, B_S6, B_S7, B_S25, B_S27, B_S23,
                B_S16} bst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run  [2];
  logic        cont [2];
  logic [15:0] ir   [2];
  logic        ben  [2];
  ovec_t       obs  [2];

  int n_total = 0;
  int n_bad   = 0;

  ovec_t expq [$];
  string tagq [$];
  int          cur_d;
  logic [15:0] cur_ir;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
    logic       g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcsel, a2sel, mode;
    logic       a1sel, drsel, sr1sel, sr2sel, mio, oe, we;

    lc3_ctrl_fsm #(.MEM_WAIT((g == 0) ? 2 : 3)) dut (
      .Clk(clk), .Reset(rst), .Run(run[g]), .Continue(cont[g]),
      .IR(ir[g]), .BEN(ben[g]),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_PC(ld_pc),
      .LD_REG(ld_reg), .LD_CC(ld_cc), .LD_BEN(ld_ben),
      .SBusPC(g_pc), .SBusMDR(g_mdr), .SBusALU(g_alu), .SBusMARMUX(g_marmux),
      .PCSelect(pcsel), .ADDR2Select(a2sel), .ADDR1Select(a1sel),
      .DRSelect(drsel), .SR1Select(sr1sel), .SR2Select(sr2sel),
      .mode(mode), .MIO_EN(mio), .Mem_OE(oe), .Mem_WE(we)
    );

    assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben,
                     g_pc, g_mdr, g_alu, g_marmux, pcsel, a2sel,
                     a1sel, drsel, sr1sel, sr2sel, mode, mio, oe, we};
  end

  task automatic check(input string tag, input ovec_t got, input ovec_t want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Expected control word per state, straight from the state descriptions.
  function automatic ovec_t exp_vec(bst_t s, bit last, logic [15:0] irv);
    ovec_t v;
    v = '0;
    v.oe = 1'b1;
    v.we = 1'b1;
    case (s)
      B_S18: begin v.g_pc = 1; v.ld_mar = 1; v.ld_pc = 1; end
      B_S33, B_S25: begin v.oe = 0; v.mio = 1; v.ld_mdr = last; end
      B_S35: begin v.g_mdr = 1; v.ld_ir = 1; end
      B_S32: v.ld_ben = 1;
      B_S1, B_S5, B_S9: begin
        v.sr1sel = 1; v.sr2sel = irv[5];
        v.mode = (s == B_S1) ? 2'b00 : (s == B_S5) ? 2'b01 : 2'b10;
        v.g_alu = 1; v.ld_reg = 1; v.ld_cc = 1;
      end
      B_S22: begin v.a2sel = 2'b10; v.pcsel = 2'b10; v.ld_pc = 1; end
      B_S12: begin v.sr1sel = 1; v.a1sel = 1; v.pcsel = 2'b10; v.ld_pc = 1; end
      B_S4:  begin v.g_pc = 1; v.drsel = 1; v.ld_reg = 1; end
      B_S21: begin v.a2sel = 2'b11; v.pcsel = 2'b10; v.ld_pc = 1; end
      B_S6, B_S7: begin
        v.sr1sel = 1; v.a1sel = 1; v.a2sel = 2'b01; v.g_marmux = 1; v.ld_mar = 1;
      end
      B_S27: begin v.g_mdr = 1; v.ld_reg = 1; v.ld_cc = 1; end
      B_S23: begin v.mode = 2'b11; v.g_alu = 1; v.ld_mdr = 1; end
      B_S16: v.we = 0;
      default: ;
    endcase
    return v;
  endfunction

  task automatic push(input bst_t s, input string nm, input bit last = 0);
    expq.push_back(exp_vec(s, last, cur_ir));
    tagq.push_back($sformatf("d%0d_%h_%s", cur_d, cur_ir, nm));
  endtask

  task automatic push_mem(input bst_t s, input string nm, input int w);
    for (int i = 0; i < w; i++) push(s, nm, i == w - 1);
  endtask

  // One cycle per expected entry; run is dropped after the first edge.
  task automatic drain();
    while (expq.size() > 0) begin
      @(negedge clk);
      run[cur_d] = 1'b0;
      check(tagq.pop_front(), obs[cur_d], expq.pop_front());
    end
  endtask

  task automatic push_fetch(input int w);
    push(B_S18, "S18");
    push_mem(B_S33, "S33", w);
    push(B_S35, "S35");
    push(B_S32, "S32");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fetch/execute one instruction from HALTED and expect the return to S18.
  task automatic run_instr(input int d, input logic [15:0] irv, input logic b);
    int w;
    w = (d == 0) ? 2 : 3;
    cur_d = d;
    cur_ir = irv;
    ir[d] = irv;
    ben[d] = b;
    run[d] = 1'b1;
    push_fetch(w);
    case (irv[15:12])
      4'b0001: push(B_S1, "S1");
      4'b0101: push(B_S5, "S5");
      4'b1001: push(B_S9, "S9");
      4'b0000: begin push(B_S0, "S0"); if (b) push(B_S22, "S22"); end
      4'b1100: push(B_S12, "S12");
      4'b0100: begin push(B_S4, "S4"); push(B_S21, "S21"); end
      4'b0110: begin push(B_S6, "S6"); push_mem(B_S25, "S25", w); push(B_S27, "S27"); end
      4'b0111: begin push(B_S7, "S7"); push(B_S23, "S23"); push_mem(B_S16, "S16", w); end
      default: ;
    endcase
    push(B_S18, "S18_back");
    drain();
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      run[i] = 1'b0; cont[i] = 1'b0; ir[i] = 16'h0000; ben[i] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("reset_d0", obs[0], exp_vec(B_IDLE, 0, 16'h0));
    check("reset_d1", obs[1], exp_vec(B_IDLE, 0, 16'h0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    cur_d = 0;
    cur_ir = 16'h0000;
    for (int i = 0; i < 3; i++) push(B_IDLE, "halt_idle");
    drain();

    run_instr(0, 16'h1261, 1'b0);
    run_instr(0, 16'h5242, 1'b0);
    run_instr(1, 16'h927F, 1'b0);
    run_instr(0, 16'h0402, 1'b1);
    run_instr(0, 16'h0402, 1'b0);
    run_instr(1, 16'h0402, 1'b1);
    run_instr(0, 16'hC040, 1'b0);
    run_instr(0, 16'h4801, 1'b0);
    run_instr(1, 16'h6042, 1'b0);
    run_instr(0, 16'h6042, 1'b0);
    run_instr(1, 16'h7042, 1'b0);
    run_instr(0, 16'h7042, 1'b0);
    run_instr(0, 16'hF025, 1'b0);

    // PAUSE: held in P1, one trip to S18 per Continue press.
    cur_d = 0;
    cur_ir = 16'hD000;
    ir[0] = 16'hD000;
    run[0] = 1'b1;
    push_fetch(2);
    for (int i = 0; i < 4; i++) push(B_IDLE, "P1_hold");
    drain();
    cont[0] = 1'b1;
    for (int i = 0; i < 5; i++) push(B_IDLE, "P2_hold");
    drain();
    cont[0] = 1'b0;
    push_fetch(2);
    for (int i = 0; i < 3; i++) push(B_IDLE, "P1_again");
    drain();
    do_reset();

    // Async reset in the middle of the fetch read.
    cur_d = 0;
    cur_ir = 16'h1261;
    ir[0] = 16'h1261;
    run[0] = 1'b1;
    push(B_S18, "pre_S18");
    push(B_S33, "pre_S33", 1'b0);
    drain();
    #2 rst = 1'b1;
    #1 check("rst_mid_s33", obs[0], exp_vec(B_IDLE, 0, 16'h0));
    @(negedge clk);
    rst = 1'b0;
    run[0] = 1'b1;
    push(B_S18, "post_rst_S18");
    push_mem(B_S33, "post_rst_S33", 2);
    drain();
    do_reset();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
